// File: rtl/prog_pulse_counter.sv
// Programmable pulse counter. It counts tick events, either rising edges or
// high cycles. After every period_r events it emits a registered one-cycle
// pulse, then reloads or stops depending on the mode latched at load.
module prog_pulse_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned EDGE  = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] period,
   input  logic             mode,
   output logic             out_pulse,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   logic             tick_d_q;
   logic             out_pulse_q, out_pulse_d;
   logic             done_q, done_d;
   logic             event_hit;

   // An event is a rising edge or a high level, depending on EDGE.
   // tick_d_q tracks tick in every state, so an edge that spans a load
   // is seen exactly once.
   assign event_hit = (EDGE != 0) ? (tick & ~tick_d_q) : tick;

   // Next-state logic. A load wins over a coincident event, and that event is dropped.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      period_d    = period_q;
      mode_d      = mode_q;
      done_d      = done_q;
      out_pulse_d = 1'b0;
      if (load) begin
         done_d = 1'b0;
         if (period != '0) begin
            period_d    = period;
            mode_d      = mode;
            remaining_d = period;
            state_d     = StRun;
         end else begin
            remaining_d = '0;
            state_d     = StIdle;
         end
      end else begin
         unique case (state_q)
            StRun: begin
               if (event_hit) begin
                  if (remaining_q == WIDTH'(1)) begin
                     out_pulse_d = 1'b1;
                     if (!mode_q) begin
                        // Reload in the same cycle so period_r=1 pulses on every event
                        remaining_d = period_q;
                     end else begin
                        remaining_d = '0;
                        done_d      = 1'b1;
                        state_d     = StDone;
                     end
                  end else if (remaining_q > WIDTH'(1)) begin
                     remaining_d = remaining_q - WIDTH'(1);
                  end
               end
            end
            StIdle, StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         period_q    <= '0;
         mode_q      <= 1'b0;
         tick_d_q    <= 1'b0;
         out_pulse_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         period_q    <= period_d;
         mode_q      <= mode_d;
         tick_d_q    <= tick;
         out_pulse_q <= out_pulse_d;
         done_q      <= done_d;
      end
   end

   assign out_pulse = out_pulse_q;
   assign remaining = remaining_q;
   assign busy      = (state_q == StRun);
   assign done      = done_q;

endmodule

// File: tb/tb_prog_pulse_counter.sv
// Self-checking bench for prog_pulse_counter: one edge-counting instance and
// one level-counting instance, with expected results queued on a scoreboard.
module tb_prog_pulse_counter;

   logic       clk = 1'b0;
   logic       resetn;
   logic       tick1, load1, tick0, load0;
   logic [7:0] period;
   logic       mode;
   logic       pulse1, busy1, done1, pulse0, busy0, done0;
   logic [7:0] rem1, rem0;

   typedef struct packed {
      logic       pulse;
      logic [7:0] rem;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t sb[$];
   exp_t e, obs;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   prog_pulse_counter #(.WIDTH(8), .EDGE(1)) dut1 (
      .clk(clk), .resetn(resetn), .tick(tick1), .load(load1), .period(period), .mode(mode),
      .out_pulse(pulse1), .remaining(rem1), .busy(busy1), .done(done1)
   );

   prog_pulse_counter #(.WIDTH(8), .EDGE(0)) dut0 (
      .clk(clk), .resetn(resetn), .tick(tick0), .load(load0), .period(period), .mode(mode),
      .out_pulse(pulse0), .remaining(rem0), .busy(busy0), .done(done0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs = {pulse1, rem1, busy1, done1};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_edge_dut: got %h expected 0", obs);
      end
      obs = {pulse0, rem0, busy0, done0};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_level_dut: got %h expected 0", obs);
      end
   endtask

   task automatic test_auto_reload();
      load1 = 1'b1; period = 8'd3; mode = 1'b0;
      step();
      load1 = 1'b0; period = 8'd7; mode = 1'b1;  // must be ignored without load
      obs = {pulse1, rem1, busy1, done1};
      checks++;
      if (obs !== {1'b0, 8'd3, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL auto_load: got %h expected %h", obs, {1'b0, 8'd3, 1'b1, 1'b0});
      end
      for (int i = 1; i <= 7; i++) begin
         e.pulse = (i % 3 == 0);
         e.rem   = (i % 3 == 0) ? 8'd3 : 8'(3 - (i % 3));
         e.busy  = 1'b1;
         e.done  = 1'b0;
         sb.push_back(e);
         tick1 = 1'b1;
         step();
         e = sb.pop_front();
         obs = {pulse1, rem1, busy1, done1};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL auto_edge%0d: got %h expected %h", i, obs, e);
         end
         tick1 = 1'b0;
         step();
         checks++;
         if (pulse1 !== 1'b0 || rem1 !== e.rem) begin
            errors++;
            $display("FAIL auto_low%0d: got pulse=%b rem=%0d expected pulse=0 rem=%0d",
                     i, pulse1, rem1, e.rem);
         end
      end
   endtask

   task automatic test_one_shot();
      load1 = 1'b1; period = 8'd2; mode = 1'b1;
      step();
      load1 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         e.pulse = (i == 2);
         e.rem   = (i == 1) ? 8'd1 : 8'd0;
         e.busy  = (i == 1);
         e.done  = (i >= 2);
         sb.push_back(e);
         tick1 = 1'b1;
         step();
         e = sb.pop_front();
         obs = {pulse1, rem1, busy1, done1};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL oneshot_edge%0d: got %h expected %h", i, obs, e);
         end
         tick1 = 1'b0;
         step();
      end
   endtask

   task automatic test_level();
      load0 = 1'b1; period = 8'd1; mode = 1'b0;
      step();
      load0 = 1'b0;
      checks++;
      if (rem0 !== 8'd1 || busy0 !== 1'b1) begin
         errors++;
         $display("FAIL level_load: got rem=%0d busy=%b expected rem=1 busy=1", rem0, busy0);
      end
      tick0 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         e = {1'b1, 8'd1, 1'b1, 1'b0};
         sb.push_back(e);
         step();
         e = sb.pop_front();
         obs = {pulse0, rem0, busy0, done0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL level_cycle%0d: got %h expected %h", i, obs, e);
         end
      end
      tick0 = 1'b0;
      step();
      checks++;
      if (pulse0 !== 1'b0) begin
         errors++;
         $display("FAIL level_end: got pulse=%b expected 0", pulse0);
      end
   endtask

   task automatic test_load_with_edge();
      load1 = 1'b1; period = 8'd4; mode = 1'b0; tick1 = 1'b1;
      step();
      load1 = 1'b0;
      obs = {pulse1, rem1, busy1, done1};
      checks++;
      if (obs !== {1'b0, 8'd4, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL load_edge: got %h expected %h", obs, {1'b0, 8'd4, 1'b1, 1'b0});
      end
      step();  // tick still high: no new edge
      checks++;
      if (rem1 !== 8'd4) begin
         errors++;
         $display("FAIL load_edge_hold: got rem=%0d expected 4", rem1);
      end
      tick1 = 1'b0;
      step();
      e = {1'b0, 8'd3, 1'b1, 1'b0};
      sb.push_back(e);
      tick1 = 1'b1;
      step();
      e = sb.pop_front();
      obs = {pulse1, rem1, busy1, done1};
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL load_edge_next: got %h expected %h", obs, e);
      end
      tick1 = 1'b0;
      step();
   endtask

   task automatic test_load_zero();
      e = {1'b0, 8'd2, 1'b1, 1'b0};
      sb.push_back(e);
      tick1 = 1'b1;
      step();
      e = sb.pop_front();
      obs = {pulse1, rem1, busy1, done1};
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL zero_pre: got %h expected %h", obs, e);
      end
      tick1 = 1'b0;
      load1 = 1'b1; period = 8'd0;
      step();
      load1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         obs = {pulse1, rem1, busy1, done1};
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL zero_idle%0d: got %h expected 0", i, obs);
         end
         tick1 = 1'b1;
         step();
         tick1 = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_mid();
      load1 = 1'b1; period = 8'd2; mode = 1'b0;
      step();
      load1 = 1'b0;
      tick1 = 1'b1;
      step();
      tick1 = 1'b0;
      checks++;
      if (rem1 !== 8'd1) begin
         errors++;
         $display("FAIL rst_pre: got rem=%0d expected 1", rem1);
      end
      #2 resetn = 1'b0;
      #1;
      obs = {pulse1, rem1, busy1, done1};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL rst_async: got %h expected 0", obs);
      end
      step();
      tick1 = 1'b1;
      step();
      resetn = 1'b1;
      tick1 = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         tick1 = 1'b1;
         step();
         obs = {pulse1, rem1, busy1, done1};
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL rst_after%0d: got %h expected 0", i, obs);
         end
         tick1 = 1'b0;
         step();
      end
      load1 = 1'b1; period = 8'd1; mode = 1'b1;
      step();
      load1 = 1'b0;
      e = {1'b1, 8'd0, 1'b0, 1'b1};
      sb.push_back(e);
      tick1 = 1'b1;
      step();
      e = sb.pop_front();
      obs = {pulse1, rem1, busy1, done1};
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL rst_reload: got %h expected %h", obs, e);
      end
      tick1 = 1'b0;
      step();
   endtask

   initial begin
      resetn = 1'b0;
      tick1 = 1'b0; load1 = 1'b0; tick0 = 1'b0; load0 = 1'b0;
      period = 8'd0; mode = 1'b0;
      step();
      step();
      test_reset();
      resetn = 1'b1;
      step();
      test_auto_reload();
      test_one_shot();
      test_level();
      test_load_with_edge();
      test_load_zero();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
